// File: rtl/posit_add_arbiter_pkg.sv
// posit_add_arbiter_pkg: shared widths and the tag type for the posit adder arbiter
package posit_add_arbiter_pkg;
    localparam int NBITS       = 32;
    localparam int ARB_NREQ    = 4;
    localparam int ARB_LATENCY = 4;
    localparam int ARB_IDW     = $clog2(ARB_NREQ);

    typedef struct packed {
        logic               valid;
        logic [ARB_IDW-1:0] id;
    } arb_tag_t;
endpackage

// File: rtl/posit_add_arbiter_rr_grant.sv
// posit_add_arbiter_rr_grant: combinational round-robin priority encoder starting at ptr
module posit_add_arbiter_rr_grant
    import posit_add_arbiter_pkg::*;
#(
    parameter int NREQ = ARB_NREQ,
    parameter int IDW  = $clog2(ARB_NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  idx,
    output logic            any
);
    int w_j;

    // scan from the farthest candidate back to ptr so the nearest requester wins
    always_comb begin
        w_j = 0;
        idx = '0;
        any = 1'b0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            w_j = (int'(ptr) + k) % NREQ;
            if (req[IDW'(w_j)]) begin
                idx = IDW'(w_j);
                any = 1'b1;
            end
        end
        gnt = any ? NREQ'(1) << idx : '0;
    end
endmodule

// File: rtl/posit_add_arbiter.sv
// posit_add_arbiter: round-robin share of one pipelined posit adder with ID-tagged responses
module posit_add_arbiter
    import posit_add_arbiter_pkg::*;
#(
    parameter int NREQ    = ARB_NREQ,
    parameter int LATENCY = ARB_LATENCY,
    localparam int IDW    = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  hold,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*NBITS-1:0] req_a,
    input  logic [NREQ*NBITS-1:0] req_b,
    output logic                  add_in_valid,
    output logic [NBITS-1:0]      add_in_a,
    output logic [NBITS-1:0]      add_in_b,
    input  logic [NBITS-1:0]      add_out_result,
    output logic                  resp_valid,
    output logic [IDW-1:0]        resp_id,
    output logic [NBITS-1:0]      resp_data,
    output logic                  busy
);
    logic [NREQ-1:0]  w_req;
    logic [NREQ-1:0]  w_gnt;
    logic [IDW-1:0]   w_idx;
    logic             w_any;
    logic [IDW-1:0]   r_ptr;
    logic             r_iss_v;
    logic [IDW-1:0]   r_iss_id;
    logic [NBITS-1:0] r_a;
    logic [NBITS-1:0] r_b;
    logic [LATENCY-1:0] r_dv;
    logic [IDW-1:0]   r_did [LATENCY];
    logic             r_resp_v;
    logic [IDW-1:0]   r_resp_id;
    logic [NBITS-1:0] r_resp_data;

    assign w_req = (reset || hold) ? '0 : req_valid;

    posit_add_arbiter_rr_grant #(.NREQ(NREQ), .IDW(IDW)) u_grant (
        .req(w_req),
        .ptr(r_ptr),
        .gnt(w_gnt),
        .idx(w_idx),
        .any(w_any)
    );

    assign req_ready    = w_gnt;
    assign add_in_valid = r_iss_v;
    assign add_in_a     = r_a;
    assign add_in_b     = r_b;
    assign resp_valid   = r_resp_v;
    assign resp_id      = r_resp_id;
    assign resp_data    = r_resp_data;
    assign busy         = r_iss_v | (|r_dv) | r_resp_v;

    // pointer moves just past the requester that was served
    always_ff @(posedge clk) begin
        if (reset)
            r_ptr <= '0;
        else if (w_any)
            r_ptr <= (int'(w_idx) == NREQ - 1) ? '0 : w_idx + 1'b1;
    end

    // issue stage captures the granted operand pair; operands hold when idle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_iss_v  <= 1'b0;
            r_iss_id <= '0;
            r_a      <= '0;
            r_b      <= '0;
        end else begin
            r_iss_v <= w_any;
            if (w_any) begin
                r_iss_id <= w_idx;
                r_a      <= req_a[w_idx*NBITS +: NBITS];
                r_b      <= req_b[w_idx*NBITS +: NBITS];
            end
        end
    end

    // tag delay line tracks the adder pipeline so the tag exits with its sum
    always_ff @(posedge clk) begin
        if (reset) begin
            r_dv <= '0;
            for (int k = 0; k < LATENCY; k++)
                r_did[k] <= '0;
        end else begin
            r_dv[0]  <= r_iss_v;
            r_did[0] <= r_iss_id;
            for (int k = 1; k < LATENCY; k++) begin
                r_dv[k]  <= r_dv[k-1];
                r_did[k] <= r_did[k-1];
            end
        end
    end

    // response stage registers the sum and owner when a tag exits
    always_ff @(posedge clk) begin
        if (reset) begin
            r_resp_v    <= 1'b0;
            r_resp_id   <= '0;
            r_resp_data <= '0;
        end else begin
            r_resp_v <= r_dv[LATENCY-1];
            if (r_dv[LATENCY-1]) begin
                r_resp_id   <= r_did[LATENCY-1];
                r_resp_data <= add_out_result;
            end
        end
    end
endmodule

// File: tb/tb_posit_add_arbiter.sv
// tb_posit_add_arbiter: randomized and directed checks against a queue-based reference model
module tb_posit_add_arbiter;
    import posit_add_arbiter_pkg::*;
    localparam int N   = ARB_NREQ;
    localparam int L   = ARB_LATENCY;
    localparam int IDW = $clog2(N);

    logic               clk = 1'b0;
    logic               reset, hold;
    logic [N-1:0]       req_valid, req_ready;
    logic [N*NBITS-1:0] req_a, req_b;
    logic               add_in_valid;
    logic [NBITS-1:0]   add_in_a, add_in_b, add_out_result;
    logic               resp_valid;
    logic [IDW-1:0]     resp_id;
    logic [NBITS-1:0]   resp_data;
    logic               busy;

    posit_add_arbiter dut (
        .clk(clk), .reset(reset), .hold(hold),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .add_in_valid(add_in_valid), .add_in_a(add_in_a), .add_in_b(add_in_b),
        .add_out_result(add_out_result),
        .resp_valid(resp_valid), .resp_id(resp_id), .resp_data(resp_data),
        .busy(busy)
    );

    always #5 clk = ~clk;

    function automatic logic [NBITS-1:0] fadd(input logic [NBITS-1:0] a, input logic [NBITS-1:0] b);
        return (a == 32'h40000000 && b == 32'h40000000) ? 32'h48000000 : a + b;
    endfunction

    logic [NBITS-1:0] pipe [L];
    always @(posedge clk) begin
        pipe[0] <= fadd(add_in_a, add_in_b);
        for (int k = 1; k < L; k++) pipe[k] <= pipe[k-1];
    end
    assign add_out_result = pipe[L-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int               id;
        logic [NBITS-1:0] d;
        int               t;
    } op_t;
    op_t q[$];
    int m_ptr = 0;
    int m_g;
    bit prev_x = 0;
    logic [NBITS-1:0] prev_a, prev_b;
    bit saw_two;
    int ncmp = 0, nerr = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        ncmp++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    always @(negedge clk) begin
        m_g = -1;
        if (!reset && !hold)
            for (int k = 0; k < N; k++)
                if (m_g < 0 && req_valid[(m_ptr + k) % N]) m_g = (m_ptr + k) % N;
        check("req_ready", 64'(req_ready), m_g < 0 ? 64'd0 : 64'd1 << m_g);
        if (!reset) begin
            check("busy", 64'(busy), 64'(q.size() != 0));
            check("add_in_valid", 64'(add_in_valid), 64'(prev_x));
            if (prev_x) begin
                check("add_in_a", 64'(add_in_a), 64'(prev_a));
                check("add_in_b", 64'(add_in_b), 64'(prev_b));
            end
            if (q.size() != 0 && q[0].t + L + 2 == cyc) begin
                check("resp_valid", 64'(resp_valid), 64'd1);
                check("resp_id", 64'(resp_id), 64'(q[0].id));
                check("resp_data", 64'(resp_data), 64'(q[0].d));
                if (resp_valid && resp_id == IDW'(1) && resp_data == 32'h48000000) saw_two = 1;
                void'(q.pop_front());
            end else
                check("resp_valid_idle", 64'(resp_valid), 64'd0);
        end
        if (reset) begin
            q.delete();
            m_ptr  = 0;
            prev_x = 0;
        end else begin
            prev_x = (m_g >= 0);
            if (m_g >= 0) begin
                prev_a = req_a[m_g*NBITS +: NBITS];
                prev_b = req_b[m_g*NBITS +: NBITS];
                q.push_back('{m_g, fadd(prev_a, prev_b), cyc});
                m_ptr = (m_g + 1) % N;
            end
        end
    end

    task automatic step(input logic [N-1:0] v, input logic h, input logic r);
        @(posedge clk);
        #1;
        reset     = r;
        hold      = h;
        req_valid = v;
        for (int i = 0; i < N; i++) begin
            req_a[i*NBITS +: NBITS] = $urandom;
            req_b[i*NBITS +: NBITS] = $urandom;
        end
    endtask

    task automatic run(input logic [N-1:0] v, input logic h, input int n);
        repeat (n) step(v, h, 1'b0);
    endtask

    task automatic check_reset_values();
        @(negedge clk);
        #1;
        check("rst_add_in_valid", 64'(add_in_valid), 64'd0);
        check("rst_add_in_a", 64'(add_in_a), 64'd0);
        check("rst_add_in_b", 64'(add_in_b), 64'd0);
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_resp_id", 64'(resp_id), 64'd0);
        check("rst_resp_data", 64'(resp_data), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        reset     = 1'b1;
        hold      = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        saw_two   = 0;
        step('0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b0);
        check_reset_values();
        run(4'b0101, 1'b0, 8);
        run(4'b0000, 1'b0, 10);
        run(4'b1111, 1'b0, 8);
        run(4'b0000, 1'b0, 10);
        run(4'b0100, 1'b0, 1);
        run(4'b1000, 1'b0, 1);
        run(4'b1001, 1'b0, 1);
        run(4'b0000, 1'b0, 10);
        run(4'b0011, 1'b0, 2);
        run(4'b1111, 1'b1, 10);
        run(4'b0000, 1'b0, 2);
        step(4'b0010, 1'b0, 1'b0);
        req_a[NBITS +: NBITS] = 32'h40000000;
        req_b[NBITS +: NBITS] = 32'h40000000;
        run(4'b0000, 1'b0, 10);
        check("one_plus_one", 64'(saw_two), 64'd1);
        run(4'b1111, 1'b0, 3);
        run(4'b0000, 1'b0, 2);
        step('0, 1'b0, 1'b1);
        step('0, 1'b0, 1'b0);
        check_reset_values();
        run(4'b0000, 1'b0, 12);
        for (int i = 0; i < 400; i++)
            step(N'($urandom), $urandom_range(0, 7) == 0, $urandom_range(0, 99) == 0);
        run(4'b0000, 1'b0, 12);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/posit_add_arbiter.md
# posit_add_arbiter

Round-robin scheduler that shares one pipelined posit adder among NREQ requesting processing elements in the PairHMM posit datapath. Accepts operand pairs through per-requester valid/ready handshakes, issues at most one operation per cycle to the adder, and returns each sum tagged with the originating requester ID. Sits between the PE array and the single adder instance.

## Interface
Parameters:
- NREQ, 4, number of requesters (≥2)
- LATENCY, 4, fixed adder latency in cycles from add_in_valid to add_out_result valid (≥1)
- IDW, $clog2(NREQ), requester ID width (derived, not overridden)

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- hold  in  1  blocks new grants; in-flight ops drain
- req_valid  in  NREQ  per-requester operand pair valid
- req_ready  out  NREQ  per-requester grant, one-hot or zero
- req_a  in  NREQ×NBITS  operand A per requester (raw posit, NBITS from posit_defines)
- req_b  in  NREQ×NBITS  operand B per requester
- add_in_valid  out  1  issue strobe to shared adder
- add_in_a  out  NBITS  operand A to adder
- add_in_b  out  NBITS  operand B to adder
- add_out_result  in  NBITS  adder sum, meaningful LATENCY cycles after add_in_valid
- resp_valid  out  1  response strobe
- resp_id  out  IDW  requester that owns resp_data
- resp_data  out  NBITS  sum
- busy  out  1  any operation accepted but not yet responded

## Operation
- Transfer on requester i when req_valid[i] & req_ready[i] in the same cycle.
- Grant combinational: scan from ptr upward modulo NREQ; first i with req_valid[i] gets req_ready[i]=1. No grant when hold=1 or no valid.
- ptr register: on transfer of i, ptr ← (i+1) mod NREQ; otherwise unchanged. Wrap from NREQ-1 to 0.
- Issue stage (registered): cycle after transfer, add_in_valid=1, add_in_a/b = captured operands; otherwise add_in_valid=0, operands hold last value.
- Tag delay line: LATENCY entries of {valid, id}, shifted each cycle, loaded from issue stage. Tag exits aligned with add_out_result.
- Response stage (registered): resp_valid/resp_id from exiting tag, resp_data ← add_out_result when tag valid; resp_data holds otherwise.
- Requesters never backpressure responses; every resp_valid is consumed.
- busy = issue-stage valid | any delay-line valid | resp_valid.
- hold asserted mid-stream: grants stop that cycle; already-accepted ops complete normally; ptr frozen.
- reset mid-operation: all in-flight tags discarded; no response emitted for them.
- Reset values: ptr=0, add_in_valid=0, add_in_a/b=0, delay line cleared, resp_valid=0, resp_id=0, resp_data=0, busy=0. req_ready is combinational: 0 while reset is high.

## Timing
- Transfer in cycle t → add_in_valid in t+1 → adder result valid at t+1+LATENCY → resp_valid in t+2+LATENCY. Total LATENCY+2.
- Throughput: one op per cycle sustained, independent of requester mix.
- Response order equals grant order.
- Single requester with continuous valid: granted every cycle.

## Structure
- Add to posit_defines: typedef arb_tag {logic valid; logic [IDW-1:0] id;} parametrized via NREQ constant (ARB_NREQ=4, ARB_LATENCY=4); operand width from NBITS.
- One sub-module natural: rr_grant (combinational round-robin priority encoder: req, ptr → one-hot grant, index, any). Delay line and stages stay in the top.

## Test plan
- Reset then req_valid=4'b0101, both held: grants alternate 0,2,0,2; resp_id sequence 0,2,0,2 with first resp_valid exactly 6 cycles (LATENCY=4) after first transfer.
- All four valid continuously for 8 cycles: grant order 0,1,2,3,0,1,2,3; add_in_valid high 8 consecutive cycles; 8 responses in same order.
- Only requester 3 valid after ptr=3 wrap: grant 3, ptr→0; next cycle requester 0 and 3 valid → 0 granted.
- hold=1 while 2 ops in flight: req_ready=0, two responses still arrive, busy drops to 0 one cycle after last resp_valid.
- Adder model returning a+b for 0x40000000 + 0x40000000 (1.0+1.0) → resp_data=0x48000000 with correct resp_id.
- reset asserted 2 cycles after three transfers: no resp_valid ever appears for them; all outputs at reset values the cycle after reset.
